control_fsm32: RTL

//   Multi-cycle control sequencer for the Minisys-1A datapath. It decodes the latched Instruction and steps
//   IF/ID/EXE/MEM/WB states, issuing per-state write enables for PC, IR, ALU-result register, register file
//   and memory/IO. It adds a counted wait state for mult/div and an address-window MEM/IO split. It sits

---
 rtl/control_fsm32.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/control_fsm32.sv
// Multi-cycle control sequencer for the Minisys-1A datapath.
// Steps IF/ID/EXE/MEM/WB (plus a counted mult/div wait state) and issues
// per-state write enables decoded from the latched instruction.
// Optional feature: define CTRL_MEMWAIT_EN to stretch SMEM until Mem_ready.
module control_fsm32 #(
  parameter int unsigned ADDR_HIGH_W   = 22,
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            Instruction,
  input  logic [ADDR_HIGH_W-1:0] Alu_resultHigh,
  input  logic                   Eq,
  input  logic                   Rs_neg,
  input  logic                   Rs_zero,
  input  logic                   Mem_ready,
  output logic [1:0]             Wpc,
  output logic                   Wir,
  output logic                   Waluresult,
  output logic                   RegWrite,
  output logic                   RegDST,
  output logic                   Link31,
  output logic                   MemIOtoReg,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IORead,
  output logic                   IOWrite,
  output logic                   Exc_req,
  output logic                   Exc_ret,
  output logic [2:0]             State
);

  localparam int unsigned CNT_W = 8;
  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  typedef enum logic [2:0] {
    S_INIT = 3'b000,
    S_IF   = 3'b001,
    S_ID   = 3'b010,
    S_EXE  = 3'b011,
    S_MEM  = 3'b100,
    S_WB   = 3'b101,
    S_MD   = 3'b110
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] md_cnt;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;

  logic is_rtype;
  logic is_load;
  logic is_store;
  logic is_branch;
  logic is_link_branch;
  logic is_muldiv;
  logic is_mtx;
  logic is_jump;
  logic is_jal;
  logic is_jalr;
  logic is_exc;
  logic is_eret;
  logic is_mfc0;
  logic br_taken;
  logic io_space;

  assign op       = Instruction[31:26];
  assign rs       = Instruction[25:21];
  assign rt       = Instruction[20:16];
  assign funct    = Instruction[5:0];
  assign is_rtype = (op == 6'b000000);
  assign io_space = &Alu_resultHigh;
  assign State    = state;

`ifndef CTRL_MEMWAIT_EN
  // Mem_ready only matters when SMEM can be stretched.
  logic unused_mem_ready;
  assign unused_mem_ready = Mem_ready;
`endif

  // Instruction class decode and branch condition evaluation.
  always_comb begin
    is_load        = 1'b0;
    is_store       = 1'b0;
    is_branch      = 1'b0;
    is_link_branch = 1'b0;
    is_muldiv      = 1'b0;
    is_mtx         = 1'b0;
    is_jump        = 1'b0;
    is_jal         = 1'b0;
    is_jalr        = 1'b0;
    is_exc         = 1'b0;
    is_eret        = 1'b0;
    is_mfc0        = 1'b0;
    br_taken       = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b001000: is_jump = 1'b1;
          6'b001001: is_jalr = 1'b1;
          6'b001100, 6'b001101: is_exc = 1'b1;
          6'b010001, 6'b010011: is_mtx = 1'b1;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: is_muldiv = 1'b1;
          6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
          6'b010000, 6'b010010,
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011: ;
          default: is_exc = 1'b1;
        endcase
      end
      6'b000001: begin
        case (rt)
          5'b00000: begin is_branch = 1'b1; br_taken = Rs_neg; end
          5'b00001: begin is_branch = 1'b1; br_taken = !Rs_neg; end
          5'b10000: begin is_branch = 1'b1; is_link_branch = 1'b1; br_taken = Rs_neg; end
          5'b10001: begin is_branch = 1'b1; is_link_branch = 1'b1; br_taken = !Rs_neg; end
          default:  is_exc = 1'b1;
        endcase
      end
      6'b000010: is_jump = 1'b1;
      6'b000011: is_jal  = 1'b1;
      6'b000100: begin is_branch = 1'b1; br_taken = Eq; end
      6'b000101: begin is_branch = 1'b1; br_taken = !Eq; end
      6'b000110: begin is_branch = 1'b1; br_taken = Rs_neg || Rs_zero; end
      6'b000111: begin is_branch = 1'b1; br_taken = !Rs_neg && !Rs_zero; end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: ;
      6'b010000: begin
        if (rs == 5'b00000)               is_mfc0 = 1'b1;
        else if (rs == 5'b00100)          is_mtx  = 1'b1;
        else if (Instruction == ERET_WORD) is_eret = 1'b1;
        else                              is_exc  = 1'b1;
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: is_load  = 1'b1;
      6'b101000, 6'b101001, 6'b101011:                       is_store = 1'b1;
      default: is_exc = 1'b1;
    endcase
  end

  // State register, transitions and mult/div dwell counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_INIT;
      md_cnt <= '0;
    end else begin
      case (state)
        S_INIT: state <= S_IF;
        S_IF:   state <= S_ID;
        S_ID: begin
          if (is_exc || is_eret || is_jump || is_jal || is_jalr) state <= S_IF;
          else                                                  state <= S_EXE;
        end
        S_EXE: begin
          if (is_load || is_store) begin
            state <= S_MEM;
          end else if (is_branch || is_mtx) begin
            state <= S_IF;
          end else if (is_muldiv) begin
            md_cnt <= CNT_W'(MULDIV_CYCLES - 1);
            state  <= S_MD;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
`ifdef CTRL_MEMWAIT_EN
          if (Mem_ready) state <= is_store ? S_IF : S_WB;
`else
          state <= is_store ? S_IF : S_WB;
`endif
        end
        S_WB: state <= S_IF;
        S_MD: begin
          if (md_cnt == '0) state  <= S_IF;
          else              md_cnt <= md_cnt - CNT_W'(1);
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Per-state datapath enables, decoded from state and instruction.
  always_comb begin
    Wpc        = 2'b00;
    Wir        = 1'b0;
    Waluresult = 1'b0;
    RegWrite   = 1'b0;
    RegDST     = 1'b0;
    Link31     = 1'b0;
    MemIOtoReg = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IORead     = 1'b0;
    IOWrite    = 1'b0;
    Exc_req    = 1'b0;
    Exc_ret    = 1'b0;
    case (state)
      S_IF: begin
        Wir = 1'b1;
        Wpc = 2'b01;
      end
      S_ID: begin
        if (is_exc) begin
          Exc_req = 1'b1;
        end else if (is_eret) begin
          Exc_ret = 1'b1;
        end else if (is_jump) begin
          Wpc = 2'b10;
        end else if (is_jal) begin
          Wpc      = 2'b10;
          RegWrite = 1'b1;
          Link31   = 1'b1;
        end else if (is_jalr) begin
          Wpc      = 2'b10;
          RegWrite = 1'b1;
          RegDST   = 1'b1;
        end
      end
      S_EXE: begin
        Waluresult = 1'b1;
        if (is_branch) begin
          Wpc = br_taken ? 2'b11 : 2'b00;
          if (is_link_branch) begin
            RegWrite = 1'b1;
            Link31   = 1'b1;
          end
        end
      end
      S_MEM: begin
        if (is_load) begin
          MemRead = !io_space;
          IORead  = io_space;
        end else if (is_store) begin
          MemWrite = !io_space;
          IOWrite  = io_space;
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        MemIOtoReg = is_load;
        RegDST     = is_rtype && !is_mfc0;
      end
      default: ;
    endcase
  end

endmodule
